// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one byte-wide UART TX serializer between three message sources
//          (0 status report, 1 event alert, 2 RX echo) with whole-message grants.
// Latency: one arbitration cycle before the first byte; data path is combinational while granted.
// Backpressure: tx_ready feeds straight back to the granted source's req_ready; a stalled
//          serializer never trips the watchdog, only a silent granted source does.
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   req_valid/req_data/req_last  per-source byte stream (source i at bit i / byte lane i)
//   req_ready                    per-source byte accepted this cycle
//   tx_data/tx_valid/tx_ready    byte stream to the serializer
//   grant, busy                  one-hot current owner, arbiter not idle
//   timeout_pulse, timeout_src   watchdog revoke strobe and index of the last revoked source
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 234,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        timeout_pulse,
  output logic [1:0]  timeout_src
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // With no gap configured a finished or revoked message drops straight back to IDLE.
  localparam state_t DONE_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t           state, state_nxt;
  logic [1:0]       last_g, last_g_nxt;
  logic [2:0]       grant_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse_nxt;
  logic [1:0]       src_nxt;

  logic [1:0] cand0, cand1, cand2, winner;
  logic       sel_vld, sel_last;
  logic [7:0] sel_dat;

  // Round-robin scan order starts at the source after the previous winner.
  always_comb begin
    case (last_g)
      2'd0:    begin cand0 = 2'd1; cand1 = 2'd2; cand2 = 2'd0; end
      2'd1:    begin cand0 = 2'd2; cand1 = 2'd0; cand2 = 2'd1; end
      default: begin cand0 = 2'd0; cand1 = 2'd1; cand2 = 2'd2; end
    endcase
    if (req_valid[cand0])      winner = cand0;
    else if (req_valid[cand1]) winner = cand1;
    else                       winner = cand2;
  end

  // last_g doubles as the index of the current owner while in XFER.
  always_comb begin
    case (last_g)
      2'd0:    begin sel_vld = req_valid[0]; sel_last = req_last[0]; sel_dat = req_data[7:0];   end
      2'd1:    begin sel_vld = req_valid[1]; sel_last = req_last[1]; sel_dat = req_data[15:8];  end
      default: begin sel_vld = req_valid[2]; sel_last = req_last[2]; sel_dat = req_data[23:16]; end
    endcase
  end

  always_comb begin
    state_nxt  = state;
    last_g_nxt = last_g;
    grant_nxt  = grant;
    cnt_nxt    = cnt;
    pulse_nxt  = 1'b0;
    src_nxt    = timeout_src;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt  = XFER;
          last_g_nxt = winner;
          grant_nxt  = 3'b001 << winner;
          cnt_nxt    = '0;
        end
      end
      XFER: begin
        // A completing byte wins over a watchdog expiry in the same cycle.
        if (sel_vld && tx_ready && sel_last) begin
          state_nxt = DONE_STATE;
          grant_nxt = '0;
          cnt_nxt   = '0;
        end else if (sel_vld) begin
          cnt_nxt = '0;
        end else if (cnt == TO_LAST) begin
          state_nxt = DONE_STATE;
          grant_nxt = '0;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
          src_nxt   = last_g;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt >= GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_g        <= 2'd2;
      grant         <= '0;
      cnt           <= '0;
      timeout_pulse <= 1'b0;
      timeout_src   <= '0;
    end else begin
      state         <= state_nxt;
      last_g        <= last_g_nxt;
      grant         <= grant_nxt;
      cnt           <= cnt_nxt;
      timeout_pulse <= pulse_nxt;
      timeout_src   <= src_nxt;
    end
  end

  // Handshake outputs are masked during reset so a byte on the wire at that
  // moment is dropped rather than reported as accepted.
  always_comb begin
    tx_data   = '0;
    tx_valid  = 1'b0;
    req_ready = '0;
    if (state == XFER && !rst) begin
      tx_data   = sel_dat;
      tx_valid  = sel_vld;
      req_ready = {3{tx_ready}} & grant;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two instances: [0] with a 4-cycle gap, [1] with no gap; both with a 16-cycle watchdog.
  logic [2:0]  rv   [2];
  logic [23:0] rd   [2];
  logic [2:0]  rl   [2];
  logic        trdy [2];
  logic        rstv [2];
  logic [2:0]  rr_o [2];
  logic [7:0]  txd  [2];
  logic        txv  [2];
  logic [2:0]  gnt  [2];
  logic        bsy  [2];
  logic        tp   [2];
  logic [1:0]  ts   [2];

  uart_tx_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rstv[0]), .req_valid(rv[0]), .req_data(rd[0]), .req_last(rl[0]),
    .req_ready(rr_o[0]), .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(trdy[0]),
    .grant(gnt[0]), .busy(bsy[0]), .timeout_pulse(tp[0]), .timeout_src(ts[0]));

  uart_tx_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rstv[1]), .req_valid(rv[1]), .req_data(rd[1]), .req_last(rl[1]),
    .req_ready(rr_o[1]), .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(trdy[1]),
    .grant(gnt[1]), .busy(bsy[1]), .timeout_pulse(tp[1]), .timeout_src(ts[1]));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: owner index (-1 none), remaining gap cycles, consecutive
  // silent cycles of the owner, previous winner, watchdog outputs.
  int gapc   [2] = '{4, 0};
  int m_own  [2] = '{-1, -1};
  int m_gap  [2] = '{0, 0};
  int m_low  [2] = '{0, 0};
  int m_rr   [2] = '{2, 2};
  int m_tsrc [2] = '{0, 0};
  bit m_pulse[2] = '{1'b0, 1'b0};

  logic [2:0] hs     [2];
  logic [2:0] prev_g [2];
  logic [9:0] blog0[$];
  logic [2:0] glog0[$];
  logic [2:0] glog1[$];
  int         gcyc1[$];
  int         bc0 = 0;
  int         pc0 = 0;

  // Source agents: queue of {last, byte} per (instance*3 + source), stall counters.
  logic [8:0] sq [6][$];
  int         st [6];
  bit         rnd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] src_of(input logic [2:0] h);
    return h[2] ? 2'd2 : (h[1] ? 2'd1 : 2'd0);
  endfunction

  always @(negedge clk) begin : cmp
    int o;
    int idx;
    bit found;
    logic [2:0] eg, err;
    logic [7:0] etd;
    logic etv, eb;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      hs[i] = rv[i] & rr_o[i];
      o = m_own[i];
      if (!rstv[i]) begin
        if (o >= 0) begin
          eg  = 3'(1 << o);
          etv = rv[i][o];
          etd = rd[i][o*8 +: 8];
          err = trdy[i] ? eg : 3'b000;
          eb  = 1'b1;
        end else begin
          eg  = 3'b000;
          etv = 1'b0;
          etd = 8'h00;
          err = 3'b000;
          eb  = (m_gap[i] > 0);
        end
        chk($sformatf("grant%0d", i), 32'(gnt[i]), 32'(eg));
        chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(eb));
        chk($sformatf("tx_valid%0d", i), 32'(txv[i]), 32'(etv));
        chk($sformatf("tx_data%0d", i), 32'(txd[i]), 32'(etd));
        chk($sformatf("req_ready%0d", i), 32'(rr_o[i]), 32'(err));
        chk($sformatf("timeout_pulse%0d", i), 32'(tp[i]), 32'(m_pulse[i]));
        chk($sformatf("timeout_src%0d", i), 32'(ts[i]), 32'(m_tsrc[i]));
        if (i == 0) begin
          if (hs[0] != 3'b000) blog0.push_back({src_of(hs[0]), txd[0]});
          if (bsy[0]) bc0++;
          if (tp[0]) pc0++;
          if (gnt[0] != prev_g[0] && gnt[0] != 3'b000) glog0.push_back(gnt[0]);
        end else if (gnt[1] != prev_g[1] && gnt[1] != 3'b000) begin
          glog1.push_back(gnt[1]);
          gcyc1.push_back(cyc);
        end
      end
      prev_g[i] = gnt[i];
      // Advance the model across the coming clock edge.
      if (rstv[i]) begin
        m_own[i] = -1; m_gap[i] = 0; m_low[i] = 0; m_rr[i] = 2;
        m_pulse[i] = 1'b0; m_tsrc[i] = 0;
      end else begin
        m_pulse[i] = 1'b0;
        if (o >= 0) begin
          if (rv[i][o] && trdy[i] && rl[i][o]) begin
            m_own[i] = -1; m_gap[i] = gapc[i];
          end else if (rv[i][o]) begin
            m_low[i] = 0;
          end else begin
            m_low[i]++;
            if (m_low[i] >= TO) begin
              m_own[i] = -1; m_gap[i] = gapc[i]; m_pulse[i] = 1'b1; m_tsrc[i] = o;
            end
          end
        end else if (m_gap[i] > 0) begin
          m_gap[i]--;
        end else if (rv[i] != 3'b000) begin
          found = 1'b0;
          for (int k = 1; k <= 3; k++) begin
            idx = (m_rr[i] + k) % 3;
            if (!found && rv[i][idx]) begin
              found = 1'b1; m_own[i] = idx; m_rr[i] = idx; m_low[i] = 0;
            end
          end
        end
      end
    end
  end

  task automatic push(input int k, input logic [7:0] b, input logic l);
    sq[k].push_back({l, b});
  endtask

  task automatic step();
    int len;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      if (hs[k/3][k%3] && sq[k].size() > 0) void'(sq[k].pop_front());
      if (rnd) begin
        if (st[k] > 0) st[k]--;
        else if ($urandom_range(0, 63) == 0) st[k] = int'($urandom_range(3, 30));
        if (sq[k].size() == 0 && $urandom_range(0, 7) == 0) begin
          len = int'($urandom_range(1, 4));
          for (int j = 0; j < len; j++) push(k, 8'($urandom), (j == len - 1));
        end
      end
      rv[k/3][k%3]           = (sq[k].size() > 0) && (st[k] == 0);
      rd[k/3][(k%3)*8 +: 8]  = (sq[k].size() > 0) ? sq[k][0][7:0] : 8'h00;
      rl[k/3][k%3]           = (sq[k].size() > 0) ? sq[k][0][8] : 1'b0;
    end
    if (rnd) begin
      for (int i = 0; i < 2; i++) begin
        trdy[i] = ($urandom_range(0, 3) != 0);
        rstv[i] = ($urandom_range(0, 499) == 0);
      end
    end
  endtask

  task automatic do_reset0();
    for (int k = 0; k < 3; k++) sq[k].delete();
    rstv[0] = 1'b1;
    step();
    step();
    rstv[0] = 1'b0;
    blog0.delete();
    glog0.delete();
    bc0 = 0;
    pc0 = 0;
  endtask

  logic [9:0] exp2 [8];
  logic [9:0] exp5 [4];
  bit hit5;

  initial begin
    for (int k = 0; k < 6; k++) st[k] = 0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = '0; rd[i] = '0; rl[i] = '0; trdy[i] = 1'b1; rstv[i] = 1'b1;
    end
    step(); step(); step();
    rstv[0] = 1'b0;
    rstv[1] = 1'b0;
    #1;
    chk("rst_grant", 32'(gnt[0]), 32'h0);
    chk("rst_busy", 32'(bsy[0]), 32'h0);
    chk("rst_tx_valid", 32'(txv[0]), 32'h0);
    chk("rst_pulse", 32'(tp[0]), 32'h0);
    chk("rst_src", 32'(ts[0]), 32'h0);

    // Single source 0 sends "HU:".
    bc0 = 0;
    push(0, 8'h48, 1'b0); push(0, 8'h55, 1'b0); push(0, 8'h3a, 1'b1);
    for (int c = 0; c < 40; c++) step();
    chk("t1_nbytes", 32'(blog0.size()), 32'd3);
    if (blog0.size() >= 3) begin
      chk("t1_byte0", 32'(blog0[0]), 32'h048);
      chk("t1_byte1", 32'(blog0[1]), 32'h055);
      chk("t1_byte2", 32'(blog0[2]), 32'h03a);
    end
    chk("t1_busy_cycles", 32'(bc0), 32'd7);
    chk("t1_ngrants", 32'(glog0.size()), 32'd1);
    chk("t1_grant", 32'(glog0[0]), 32'h1);
    chk("t1_idle_grant", 32'(gnt[0]), 32'h0);

    // All three sources, 2-byte messages, source 0 has two.
    do_reset0();
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
    push(2, 8'h30, 1'b0); push(2, 8'h31, 1'b1);
    exp2 = '{10'h010, 10'h011, 10'h120, 10'h121, 10'h230, 10'h231, 10'h012, 10'h013};
    for (int c = 0; c < 60; c++) step();
    chk("t2_ngrants", 32'(glog0.size()), 32'd4);
    if (glog0.size() >= 4) begin
      chk("t2_g0", 32'(glog0[0]), 32'h1);
      chk("t2_g1", 32'(glog0[1]), 32'h2);
      chk("t2_g2", 32'(glog0[2]), 32'h4);
      chk("t2_g3", 32'(glog0[3]), 32'h1);
    end
    chk("t2_nbytes", 32'(blog0.size()), 32'd8);
    if (blog0.size() >= 8)
      for (int j = 0; j < 8; j++) chk($sformatf("t2_byte%0d", j), 32'(blog0[j]), 32'(exp2[j]));

    // Source 1 granted, serializer stalled for 1000 cycles.
    do_reset0();
    trdy[0] = 1'b0;
    push(1, 8'ha0, 1'b0); push(1, 8'ha1, 1'b1);
    step(); step(); step();
    chk("t3_granted", 32'(gnt[0]), 32'h2);
    for (int c = 0; c < 1000; c++) step();
    chk("t3_still_granted", 32'(gnt[0]), 32'h2);
    chk("t3_ready_low", 32'(rr_o[0]), 32'h0);
    chk("t3_no_bytes", 32'(blog0.size()), 32'd0);
    trdy[0] = 1'b1;
    #1;
    chk("t3_ready_follows", 32'(rr_o[0]), 32'h2);
    for (int c = 0; c < 20; c++) step();
    chk("t3_nbytes", 32'(blog0.size()), 32'd2);
    chk("t3_byte0", 32'(blog0[0]), 32'h1a0);
    chk("t3_no_timeout", 32'(pc0), 32'd0);

    // Source 2 goes silent after its first byte; source 0 waits.
    do_reset0();
    push(2, 8'hb0, 1'b0);
    for (int c = 0; c < 5; c++) step();
    push(0, 8'hc0, 1'b1);
    for (int c = 0; c < 40; c++) step();
    chk("t4_pulses", 32'(pc0), 32'd1);
    chk("t4_src", 32'(ts[0]), 32'd2);
    chk("t4_ngrants", 32'(glog0.size()), 32'd2);
    if (glog0.size() >= 2) begin
      chk("t4_g0", 32'(glog0[0]), 32'h4);
      chk("t4_g1", 32'(glog0[1]), 32'h1);
    end
    chk("t4_nbytes", 32'(blog0.size()), 32'd2);
    if (blog0.size() >= 2) chk("t4_byte1", 32'(blog0[1]), 32'h0c0);

    // Reset while source 0 presents its second byte.
    do_reset0();
    push(0, 8'hd0, 1'b0); push(0, 8'hd1, 1'b0); push(0, 8'hd2, 1'b1);
    hit5 = 1'b0;
    for (int c = 0; c < 12 && !hit5; c++) begin
      step();
      if (sq[0].size() == 2 && gnt[0] == 3'b001) hit5 = 1'b1;
    end
    chk("t5_reached_byte2", 32'(hit5), 32'd1);
    rstv[0] = 1'b1;
    push(1, 8'he0, 1'b1);
    step();
    rstv[0] = 1'b0;
    glog0.delete();
    #1;
    chk("t5_grant", 32'(gnt[0]), 32'h0);
    chk("t5_tx_valid", 32'(txv[0]), 32'h0);
    chk("t5_busy", 32'(bsy[0]), 32'h0);
    for (int c = 0; c < 20; c++) step();
    chk("t5_first_winner", 32'(glog0[0]), 32'h1);
    exp5 = '{10'h0d0, 10'h0d1, 10'h0d2, 10'h1e0};
    chk("t5_nbytes", 32'(blog0.size()), 32'd4);
    if (blog0.size() >= 4)
      for (int j = 0; j < 4; j++) chk($sformatf("t5_byte%0d", j), 32'(blog0[j]), 32'(exp5[j]));

    // No-gap instance: single-byte message then pending source 1.
    glog1.delete();
    gcyc1.delete();
    push(3, 8'h0a, 1'b1);
    push(4, 8'hf0, 1'b1);
    for (int c = 0; c < 10; c++) step();
    chk("t6_ngrants", 32'(glog1.size()), 32'd2);
    if (glog1.size() >= 2) begin
      chk("t6_g0", 32'(glog1[0]), 32'h1);
      chk("t6_g1", 32'(glog1[1]), 32'h2);
      chk("t6_spacing", 32'(gcyc1[1] - gcyc1[0]), 32'd2);
    end

    // Randomized traffic with stalls, backpressure and occasional resets.
    rnd = 1'b1;
    for (int c = 0; c < 4000; c++) step();
    rnd = 1'b0;
    for (int i = 0; i < 2; i++) rstv[i] = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
